imem_loader: RTL and testbench

Serial program loader and port mux for the 20-word instruction memory. Receives a framed byte stream from the UART receiver, assembles little-endian 32-bit words, and writes them through the memory's synchronous write port. While loading it owns the memory address port and holds the core in reset; otherwise it forwards the core PC. It reports completion or error to the top level.

---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Groups the loader's byte-stream input, core fetch address and instruction-memory
//   port into one bundle.
//   rx_valid/rx_data  : one-cycle byte strobe from the UART receiver
//   core_pc           : core fetch address, forwarded to A when not loading
//   A/WE/WD           : instruction-memory address, write enable, write data
//   core_hold         : keeps the core in reset while a program is being loaded
//   load_done/err     : sticky completion / failure flags for the top level
//   Modports: slave = the loader, master = the surrounding system (or a bench).
interface imem_loader_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic [31:0] core_pc;
   logic [31:0] A;
   logic        WE;
   logic [31:0] WD;
   logic        core_hold;
   logic        load_done;
   logic        load_err;

   modport slave (
      input  rx_valid, rx_data, core_pc,
      output A, WE, WD, core_hold, load_done, load_err
   );

   modport master (
      output rx_valid, rx_data, core_pc,
      input  A, WE, WD, core_hold, load_done, load_err
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Serial program loader and address mux for the instruction memory. Accepts the frame
//   SYNC, N, N*4 data bytes (little-endian words), CHK (XOR of data bytes), writes each
//   assembled word through the memory's synchronous write port and holds the core in
//   reset while loading. Outside a load the memory address follows the core PC.
//   CLK   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : imem_loader_if.slave (byte stream in, memory port and status out)
module imem_loader #(
   parameter int unsigned DEPTH   = 20,
   parameter int unsigned TIMEOUT = 1_000_000,
   parameter logic [7:0]  SYNC    = 8'hA5
) (
   input logic          CLK,
   input logic          rst_n,
   imem_loader_if.slave bus
);

   localparam int unsigned IdxW = $clog2(DEPTH + 1);
   localparam int unsigned GapW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {StIdle, StCount, StData, StWrite, StCheck} state_e;

   state_e            state_q;
   logic              core_hold_q;
   logic              we_q;
   logic [31:0]       wd_q;
   logic              load_done_q;
   logic              load_err_q;
   logic [IdxW-1:0]   load_idx_q;
   logic [1:0]        byte_cnt_q;
   logic [7:0]        xor_acc_q;
   logic [31:0]       word_buf_q;
   logic [7:0]        n_q;
   logic [GapW-1:0]   gap_q;

   logic [31:0]       word_next;
   logic              timeout;
   logic              n_bad;

   // Word buffer with the incoming byte dropped into its lane.
   always_comb begin
      word_next = word_buf_q;
      word_next[8*byte_cnt_q +: 8] = bus.rx_data;
   end

   // A full TIMEOUT idle cycles inside a frame ends it.
   assign timeout = (state_q != StIdle) && !bus.rx_valid && (gap_q == GapW'(TIMEOUT - 1));
   assign n_bad   = (bus.rx_data == 8'd0) || (32'(bus.rx_data) > DEPTH);

   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         core_hold_q <= 1'b0;
         we_q        <= 1'b0;
         wd_q        <= '0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
         load_idx_q  <= '0;
         byte_cnt_q  <= '0;
         xor_acc_q   <= '0;
         word_buf_q  <= '0;
         n_q         <= '0;
         gap_q       <= '0;
      end else begin
         we_q <= 1'b0;

         if (state_q != StIdle) begin
            if (bus.rx_valid) begin
               gap_q <= '0;
            end else begin
               gap_q <= gap_q + GapW'(1);
            end
         end

         case (state_q)
            StIdle: begin
               if (bus.rx_valid && bus.rx_data == SYNC) begin
                  state_q     <= StCount;
                  core_hold_q <= 1'b1;
                  load_done_q <= 1'b0;
                  load_err_q  <= 1'b0;
                  load_idx_q  <= '0;
                  byte_cnt_q  <= '0;
                  xor_acc_q   <= '0;
                  gap_q       <= '0;
               end
            end
            StCount: begin
               if (bus.rx_valid) begin
                  if (n_bad) begin
                     load_err_q <= 1'b1;
                     state_q    <= StIdle;
                  end else begin
                     n_q     <= bus.rx_data;
                     state_q <= StData;
                  end
               end
            end
            StData: begin
               if (bus.rx_valid) begin
                  word_buf_q <= word_next;
                  xor_acc_q  <= xor_acc_q ^ bus.rx_data;
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd3) begin
                     we_q    <= 1'b1;
                     wd_q    <= word_next;
                     state_q <= StWrite;
                  end
               end
            end
            StWrite: begin
               // Any byte arriving here is dropped; the UART cannot deliver one this soon.
               load_idx_q <= load_idx_q + IdxW'(1);
               byte_cnt_q <= '0;
               if (8'(load_idx_q) + 8'd1 == n_q) begin
                  state_q <= StCheck;
               end else begin
                  state_q <= StData;
               end
            end
            StCheck: begin
               if (bus.rx_valid) begin
                  state_q <= StIdle;
                  if (bus.rx_data == xor_acc_q) begin
                     load_done_q <= 1'b1;
                     core_hold_q <= 1'b0;
                  end else begin
                     load_err_q <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase

         // core_hold stays high: memory may already be partially overwritten.
         if (timeout) begin
            load_err_q <= 1'b1;
            state_q    <= StIdle;
         end
      end
   end

   assign bus.A         = core_hold_q ? {{(30 - IdxW){1'b0}}, load_idx_q, 2'b00} : bus.core_pc;
   assign bus.WE        = we_q;
   assign bus.WD        = wd_q;
   assign bus.core_hold = core_hold_q;
   assign bus.load_done = load_done_q;
   assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed frames against imem_loader, with a frame-level model that predicts every
//   registered output each cycle, plus literal expectations for the directed cases.
module tb_imem_loader;

   localparam int unsigned DEPTH   = 20;
   localparam int unsigned TIMEOUT = 40;
   localparam logic [7:0]  SYNC    = 8'hA5;

   logic CLK = 1'b0;
   logic rst_n;

   imem_loader_if bus ();

   imem_loader #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT),
      .SYNC    (SYNC)
   ) dut (
      .CLK   (CLK),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Memory behind the write port, plus a log of every write.
   logic [31:0] mem [0:31];
   int          we_count = 0;
   logic [31:0] last_addr;
   logic [31:0] last_data;
   logic [31:0] first_addr;
   logic [31:0] first_data;

   // Frame contents sent by send_frame.
   logic [31:0] frame_words [0:31];

   // Model state: position of the next byte within the frame decides its role.
   bit          m_in_frame;
   bit          m_wcycle;
   int          m_pos;
   int          m_n;
   int          m_gap;
   int          m_words;
   logic [7:0]  m_xacc;
   logic [31:0] m_wbuf;
   logic        exp_hold;
   logic        exp_done;
   logic        exp_err;
   logic        exp_we;
   logic [31:0] exp_wd;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_frame_err();
      exp_err    = 1'b1;
      m_in_frame = 1'b0;
   endtask

   task automatic model_step();
      logic [7:0] b;
      bit         was_w;
      if (!rst_n) begin
         m_in_frame = 0; m_wcycle = 0; m_pos = 0; m_n = 0; m_gap = 0; m_words = 0;
         m_xacc = '0; m_wbuf = '0;
         exp_hold = 0; exp_done = 0; exp_err = 0; exp_we = 0; exp_wd = '0;
         return;
      end
      b      = bus.rx_data;
      was_w  = m_wcycle;
      exp_we = 1'b0;
      if (was_w) begin
         m_wcycle = 0;
         m_words++;
      end
      if (m_in_frame) begin
         if (bus.rx_valid) begin
            m_gap = 0;
         end else begin
            m_gap++;
            if (m_gap >= int'(TIMEOUT)) model_frame_err();
         end
      end
      if (bus.rx_valid && !was_w) begin
         if (!m_in_frame) begin
            if (b == SYNC) begin
               m_in_frame = 1; m_pos = 1; m_gap = 0; m_words = 0; m_xacc = '0;
               exp_hold = 1; exp_done = 0; exp_err = 0;
            end
         end else if (m_pos == 1) begin
            if (b == 8'd0 || int'(b) > int'(DEPTH)) begin
               model_frame_err();
            end else begin
               m_n   = int'(b);
               m_pos = 2;
            end
         end else if (m_pos < 4 * m_n + 2) begin
            m_xacc = m_xacc ^ b;
            m_wbuf = {b, m_wbuf[31:8]};
            if ((m_pos - 2) % 4 == 3) begin
               exp_we   = 1'b1;
               exp_wd   = m_wbuf;
               m_wcycle = 1;
            end
            m_pos++;
         end else begin
            if (b == m_xacc) begin
               exp_done   = 1'b1;
               exp_hold   = 1'b0;
               m_in_frame = 0;
            end else begin
               model_frame_err();
            end
         end
      end
   endtask

   task automatic compare();
      check32("we", 32'(bus.WE), 32'(exp_we));
      check32("core_hold", 32'(bus.core_hold), 32'(exp_hold));
      check32("load_done", 32'(bus.load_done), 32'(exp_done));
      check32("load_err", 32'(bus.load_err), 32'(exp_err));
      check32("addr", bus.A, exp_hold ? 32'(m_words * 4) : bus.core_pc);
      if (exp_we) check32("wd", bus.WD, exp_wd);
   endtask

   // Model and per-cycle compare; inputs change only on the falling edge.
   initial begin
      forever begin
         @(posedge CLK);
         model_step();
         #1;
         compare();
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      forever begin
         @(posedge CLK);
         if (bus.WE) begin
            mem[bus.A[6:2]] = bus.WD;
            if (we_count == 0) begin
               first_addr = bus.A;
               first_data = bus.WD;
            end
            we_count++;
            last_addr = bus.A;
            last_data = bus.WD;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(negedge CLK);
      bus.rx_valid = 1'b0;
   endtask

   function automatic logic [7:0] words_xor(input int n);
      logic [7:0] x = '0;
      for (int i = 0; i < n; i++) begin
         x = x ^ frame_words[i][7:0] ^ frame_words[i][15:8] ^ frame_words[i][23:16]
               ^ frame_words[i][31:24];
      end
      return x;
   endfunction

   task automatic send_frame(input int n, input logic [7:0] chk);
      send_byte(SYNC);
      send_byte(8'(n));
      for (int w = 0; w < n; w++) begin
         for (int k = 0; k < 4; k++) send_byte(frame_words[w][8*k +: 8]);
      end
      send_byte(chk);
      repeat (2) @(negedge CLK);
   endtask

   task automatic load_test_frame();
      frame_words[0] = 32'h0000_0013;
      frame_words[1] = 32'h0050_0093;
   endtask

   int base;

   initial begin
      rst_n        = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.core_pc  = 32'h0000_0000;
      repeat (3) @(negedge CLK);
      check32("reset_hold", 32'(bus.core_hold), 32'd0);
      check32("reset_we", 32'(bus.WE), 32'd0);
      check32("reset_wd", bus.WD, 32'd0);
      check32("reset_done", 32'(bus.load_done), 32'd0);
      check32("reset_err", 32'(bus.load_err), 32'd0);
      rst_n = 1'b1;

      // Idle passthrough with non-SYNC bytes mixed in.
      for (int i = 0; i <= 20; i++) begin
         @(negedge CLK);
         bus.core_pc  = 32'(i * 4);
         bus.rx_valid = (i % 3 == 0);
         bus.rx_data  = (i % 2 == 1) ? 8'hFF : 8'h00;
      end
      @(negedge CLK);
      bus.rx_valid = 1'b0;
      check32("idle_no_we", 32'(we_count), 32'd0);
      check32("idle_hold", 32'(bus.core_hold), 32'd0);
      bus.core_pc = 32'h0000_1000;

      // Good load: data bytes XOR to 0xD0.
      load_test_frame();
      base = we_count;
      send_frame(2, 8'hD0);
      check32("good_we_count", 32'(we_count - base), 32'd2);
      check32("good_first_addr", first_addr, 32'h0);
      check32("good_first_data", first_data, 32'h0000_0013);
      check32("good_last_addr", last_addr, 32'h4);
      check32("good_last_data", last_data, 32'h0050_0093);
      check32("good_done", 32'(bus.load_done), 32'd1);
      check32("good_hold", 32'(bus.core_hold), 32'd0);
      check32("mem0", mem[0], 32'h0000_0013);
      check32("mem1", mem[1], 32'h0050_0093);
      bus.core_pc = 32'h4;
      #1;
      check32("readback_pc4", mem[bus.A[6:2]], 32'h0050_0093);

      // Bad checksum, then a good frame recovers.
      base = we_count;
      send_frame(2, 8'h00);
      check32("badchk_we_count", 32'(we_count - base), 32'd2);
      check32("badchk_err", 32'(bus.load_err), 32'd1);
      check32("badchk_done", 32'(bus.load_done), 32'd0);
      check32("badchk_hold", 32'(bus.core_hold), 32'd1);
      send_frame(2, 8'hD0);
      check32("recover_err", 32'(bus.load_err), 32'd0);
      check32("recover_hold", 32'(bus.core_hold), 32'd0);

      // Count bounds.
      base = we_count;
      send_byte(SYNC);
      send_byte(8'd0);
      repeat (2) @(negedge CLK);
      check32("n0_err", 32'(bus.load_err), 32'd1);
      send_byte(SYNC);
      send_byte(8'd21);
      repeat (2) @(negedge CLK);
      check32("n21_err", 32'(bus.load_err), 32'd1);
      check32("nbad_no_we", 32'(we_count - base), 32'd0);

      for (int i = 0; i < 20; i++) frame_words[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
      base = we_count;
      send_frame(20, words_xor(20));
      check32("n20_we_count", 32'(we_count - base), 32'd20);
      check32("n20_last_addr", last_addr, 32'h4C);
      check32("n20_last_data", last_data, 32'h1013_2639);
      check32("n20_done", 32'(bus.load_done), 32'd1);

      // Timeout after two data bytes of a one-word frame.
      base = we_count;
      send_byte(SYNC);
      send_byte(8'd1);
      send_byte(8'h11);
      send_byte(8'h22);
      repeat (TIMEOUT / 2) @(negedge CLK);
      check32("timeout_early_err", 32'(bus.load_err), 32'd0);
      repeat (TIMEOUT) @(negedge CLK);
      check32("timeout_err", 32'(bus.load_err), 32'd1);
      check32("timeout_hold", 32'(bus.core_hold), 32'd1);
      check32("timeout_no_we", 32'(we_count - base), 32'd0);
      load_test_frame();
      send_frame(2, 8'hD0);
      check32("after_timeout_done", 32'(bus.load_done), 32'd1);

      // Reset after the 5th data byte.
      send_byte(SYNC);
      send_byte(8'd2);
      send_byte(8'hDD);
      send_byte(8'hCC);
      send_byte(8'hBB);
      send_byte(8'hAA);
      send_byte(8'h44);
      rst_n = 1'b0;
      @(negedge CLK);
      check32("rst_hold", 32'(bus.core_hold), 32'd0);
      check32("rst_done", 32'(bus.load_done), 32'd0);
      check32("rst_err", 32'(bus.load_err), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge CLK);
      check32("rst_mem0", mem[0], 32'hAABB_CCDD);
      check32("rst_mem1", mem[1], 32'h0050_0093);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
